aura_mem_responder: RTL and testbench
=====================================

# aura_mem_responder

Synthesizable main-memory responder for the AURA accelerator: the memory-side end of the tagged block interface driven by the memory controller. It accepts one load or store command per cycle and returns a nonzero transaction tag on acceptance. Load data comes back a fixed number of cycles later, tagged. It also provides a backdoor write port so benches can preload Q/K/V tiles before the accelerator leaves reset.

## Interface
Parameters:
- MEM_DEPTH_BLOCKS, 4096: number of 64-bit blocks stored; power of two.
- MEM_LATENCY, 4: cycles from load acceptance to data return; must be ≥1.
- MAX_OUTSTANDING, 8: maximum loads in flight; must be 1..15.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- proc2mem_command  in  MEM_COMMAND  MEM_NONE / MEM_LOAD / MEM_STORE.
- proc2mem_addr  in  ADDR (32)  byte address; bits [2:0] are ignored.
- proc2mem_data  in  MEM_BLOCK (64)  store data.
- mem2proc_transaction_tag  out  MEM_TAG (4)  combinational; 0 means rejected or no command, nonzero means accepted.
- mem2proc_data  out  MEM_BLOCK (64)  registered load return data.
- mem2proc_data_tag  out  MEM_TAG (4)  registered; nonzero marks a valid return for that tag.
- bd_we  in  1  backdoor write enable.
- bd_addr  in  log2(MEM_DEPTH_BLOCKS)  backdoor block index.
- bd_data  in  MEM_BLOCK  backdoor write data.

## Operation
- Block index is proc2mem_addr[3 +: log2(MEM_DEPTH_BLOCKS)]. An address is out of range when any higher bit is nonzero.
- State:
  - storage array;
  - next_tag (4 bits; cycles 1→15→1, never 0);
  - outstanding counter (0..MAX_OUTSTANDING);
  - return pipeline of MEM_LATENCY stages holding {tag, data}.
- LOAD accepted iff rst=0 and outstanding < MAX_OUTSTANDING, using the register value with no same-cycle bypass. On acceptance:
  - transaction_tag = next_tag;
  - read data is captured at the acceptance cycle, and is 0 when out of range;
  - {next_tag, data} enters pipeline stage 0;
  - next_tag advances.
- LOAD rejected: transaction_tag = 0; no state change. The controller retries.
- STORE: always accepted while rst=0.
  - transaction_tag = next_tag, but next_tag does not advance and no data return is produced.
  - Array is written at the clock edge; out-of-range stores are dropped.
- MEM_NONE: transaction_tag = 0.
- Ordering: a store at cycle t is visible to a load accepted at t+1 or later.
- Backdoor: bd_we writes at the clock edge and is honoured during rst. If a store and bd_we hit the same index in the same cycle, the store wins.
- Outstanding counter:
  - +1 on load acceptance;
  - −1 when a nonzero tag exits the pipeline;
  - unchanged when both happen in the same cycle.
- Tag uniqueness: returns are in order and at most MAX_OUTSTANDING ≤ 15 loads are in flight, so round-robin tags are unique.

## Timing
- A load accepted in cycle t has data_tag/data valid during cycle t+MEM_LATENCY, for exactly one cycle.
- In other cycles mem2proc_data_tag = 0 and mem2proc_data = 0.
- Back-to-back loads return on back-to-back cycles. Returns never collide, because there is one acceptance per cycle and latency is fixed.
- Throughput is one command per cycle. Loads stall (tag 0) only at the outstanding cap. A slot freed by a return in cycle c is usable in cycle c+1.
- Reset (synchronous, any time):
  - pipeline cleared;
  - outstanding = 0;
  - next_tag = 1;
  - mem2proc_data_tag = 0 and mem2proc_data = 0 from the next edge;
  - mem2proc_transaction_tag = 0 while rst=1;
  - in-flight loads are dropped and never returned;
  - storage contents are preserved.
- After rst deasserts, the first accepted command gets tag 1.

## Test plan
- Preload blocks 0..3 via backdoor with 64'hA0..A3. Load addr 0x8 at cycle t → transaction_tag=1 in cycle t; data_tag=1, data=64'hA1 in cycle t+4; zeros elsewhere.
- 10 consecutive loads, MAX_OUTSTANDING=8 → tags 1..8, then 0 for loads 9–10 until the first return. The retry in the cycle after tag 1 returns gets tag 9.
- Store 64'hDEAD at addr 0x40, then load 0x40 the next cycle → store tag is nonzero and next_tag is unchanged. The load returns 64'hDEAD after MEM_LATENCY.
- Issue 20 accepted loads paced at 7 in flight → tags wrap 15→1 and never produce 0. Each return carries the data for its own address.
- Assert rst for 1 cycle with 3 loads in flight → no returns appear. The next load gets tag 1. Preloaded data still reads back correctly.
- Out-of-range load (addr bit above index set) returns 64'h0. An out-of-range store leaves all in-range blocks unchanged.

Source files
------------

// File: rtl/aura_mem_responder_if.sv
// Tagged block bus between the memory controller (master) and main memory (slave).
// Commands: 0 = none, 1 = load, 2 = store.
interface aura_mem_responder_if;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_transaction_tag;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_data_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );
endinterface

// File: rtl/aura_mem_responder.sv
// Main-memory responder for the AURA accelerator: tagged loads with fixed return latency,
// untagged-return stores, an outstanding-load cap and a backdoor preload port.
module aura_mem_responder #(
  parameter int MEM_DEPTH_BLOCKS = 4096,
  parameter int MEM_LATENCY      = 4,
  parameter int MAX_OUTSTANDING  = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  aura_mem_responder_if.slave                 bus,
  input  logic                                bd_we,
  input  logic [$clog2(MEM_DEPTH_BLOCKS)-1:0] bd_addr,
  input  logic [63:0]                         bd_data
);
  localparam int         IDX_W     = $clog2(MEM_DEPTH_BLOCKS);
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;
  localparam logic [3:0] MAX_OUT   = 4'(MAX_OUTSTANDING);

  logic [63:0]      mem [MEM_DEPTH_BLOCKS];
  logic [3:0]       pipe_tag  [MEM_LATENCY];
  logic [63:0]      pipe_data [MEM_LATENCY];
  logic [3:0]       next_tag;
  logic [3:0]       outstanding;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             load_ok;
  logic             store_ok;
  logic             retire;
  logic [63:0]      rd_data;
  logic             unused_addr_bits;

  assign idx              = bus.proc2mem_addr[3 +: IDX_W];
  assign in_range         = ~|bus.proc2mem_addr[31:3+IDX_W];
  assign unused_addr_bits = ^bus.proc2mem_addr[2:0];

  // The cap uses the registered count only; a slot freed this cycle is usable next cycle.
  assign load_ok  = !rst && (bus.proc2mem_command == MEM_LOAD) && (outstanding < MAX_OUT);
  assign store_ok = !rst && (bus.proc2mem_command == MEM_STORE);
  assign retire   = (pipe_tag[MEM_LATENCY-1] != 4'd0);
  assign rd_data  = in_range ? mem[idx] : 64'd0;

  assign bus.mem2proc_transaction_tag = (load_ok || store_ok) ? next_tag : 4'd0;
  assign bus.mem2proc_data_tag        = pipe_tag[MEM_LATENCY-1];
  assign bus.mem2proc_data            = pipe_data[MEM_LATENCY-1];

  // Storage is never reset; the later write gives the bus store priority over the backdoor.
  always_ff @(posedge clk) begin
    if (bd_we)
      mem[bd_addr] <= bd_data;
    if (store_ok && in_range)
      mem[idx] <= bus.proc2mem_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_tag[i]  <= 4'd0;
        pipe_data[i] <= 64'd0;
      end
    end else begin
      pipe_tag[0]  <= load_ok ? next_tag : 4'd0;
      pipe_data[0] <= load_ok ? rd_data  : 64'd0;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_tag[i]  <= pipe_tag[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      next_tag <= 4'd1;
    else if (load_ok)
      next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      outstanding <= 4'd0;
    else if (load_ok && !retire)
      outstanding <= outstanding + 4'd1;
    else if (!load_ok && retire)
      outstanding <= outstanding - 4'd1;
  end
endmodule

// File: tb/tb_aura_mem_responder.sv
// Bench for aura_mem_responder: two instances (default latency, and a long-latency one that
// reaches the outstanding cap) checked every cycle against a return-schedule scoreboard.
module tb_aura_mem_responder;
  localparam int DEPTH = 4096;
  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [63:0] bd_data;

  always #5 clk = ~clk;

  aura_mem_responder_if if_a ();
  aura_mem_responder_if if_b ();

  aura_mem_responder #(.MEM_DEPTH_BLOCKS(DEPTH), .MEM_LATENCY(4), .MAX_OUTSTANDING(8)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data)
  );

  aura_mem_responder #(.MEM_DEPTH_BLOCKS(DEPTH), .MEM_LATENCY(10), .MAX_OUTSTANDING(8)) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data)
  );

  // One scheduled return per accepted load: which instance, the cycle it must appear, tag, data.
  typedef struct {
    int          inst;
    int          ret;
    logic [3:0]  tag;
    logic [63:0] data;
  } fl_t;

  fl_t         fl[$];
  int          nt[2]    = '{1, 1};
  int          lat_m[2] = '{4, 10};
  int          max_m[2] = '{8, 8};
  logic [63:0] mem_m [DEPTH];
  int          cyc      = 0;
  int          pass_cnt = 0;
  int          total    = 0;
  bit          armed    = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h at cycle %0d", name, obs, exp, cyc);
  endtask

  task automatic step(input logic r, input logic [1:0] cmd, input logic [31:0] addr,
                      input logic [63:0] d, input logic bw, input logic [11:0] ba,
                      input logic [63:0] bdd);
    int          idx;
    bit          inr;
    logic [63:0] rd;
    int          outst;
    logic [3:0]  et;
    logic [3:0]  ett;
    logic [63:0] etd;
    logic [3:0]  ot[2];
    logic [3:0]  odt[2];
    logic [63:0] od[2];
    fl_t         keep[$];

    @(negedge clk);
    rst     = r;
    bd_we   = bw;
    bd_addr = ba;
    bd_data = bdd;
    if_a.proc2mem_command = cmd;
    if_a.proc2mem_addr    = addr;
    if_a.proc2mem_data    = d;
    if_b.proc2mem_command = cmd;
    if_b.proc2mem_addr    = addr;
    if_b.proc2mem_data    = d;
    #1;
    ot[0]  = if_a.mem2proc_transaction_tag;
    odt[0] = if_a.mem2proc_data_tag;
    od[0]  = if_a.mem2proc_data;
    ot[1]  = if_b.mem2proc_transaction_tag;
    odt[1] = if_b.mem2proc_data_tag;
    od[1]  = if_b.mem2proc_data;

    // Drop returns already delivered in earlier cycles.
    keep.delete();
    foreach (fl[k]) if (fl[k].ret >= cyc) keep.push_back(fl[k]);
    fl = keep;

    idx = int'(addr[14:3]);
    inr = (addr[31:15] == 17'd0);
    rd  = inr ? mem_m[idx] : 64'd0;

    for (int i = 0; i < 2; i++) begin
      outst = 0;
      ett   = 4'd0;
      etd   = 64'd0;
      foreach (fl[k]) begin
        if (fl[k].inst == i) begin
          outst++;
          if (fl[k].ret == cyc) begin
            ett = fl[k].tag;
            etd = fl[k].data;
          end
        end
      end
      et = 4'd0;
      if (!r && cmd == C_STORE)
        et = 4'(nt[i]);
      if (!r && cmd == C_LOAD && outst < max_m[i]) begin
        et = 4'(nt[i]);
        fl.push_back('{inst: i, ret: cyc + lat_m[i], tag: 4'(nt[i]), data: rd});
        nt[i] = (nt[i] == 15) ? 1 : nt[i] + 1;
      end
      chk($sformatf("txn_tag[%0d]", i), 64'(ot[i]), 64'(et));
      if (armed) begin
        chk($sformatf("data_tag[%0d]", i), 64'(odt[i]), 64'(ett));
        chk($sformatf("data[%0d]", i), od[i], etd);
      end
      if (r) begin
        keep.delete();
        foreach (fl[k]) if (fl[k].inst != i) keep.push_back(fl[k]);
        fl    = keep;
        nt[i] = 1;
      end
    end

    if (bw) mem_m[ba] = bdd;
    if (!r && cmd == C_STORE && inr) mem_m[idx] = d;
    if (r) armed = 1'b1;
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, C_NONE, 32'd0, 64'd0, 1'b0, 12'd0, 64'd0);
  endtask

  task automatic ld(input logic [31:0] addr);
    step(1'b0, C_LOAD, addr, 64'd0, 1'b0, 12'd0, 64'd0);
  endtask

  task automatic st(input logic [31:0] addr, input logic [63:0] d);
    step(1'b0, C_STORE, addr, d, 1'b0, 12'd0, 64'd0);
  endtask

  task automatic do_reset();
    step(1'b1, C_NONE, 32'd0, 64'd0, 1'b0, 12'd0, 64'd0);
  endtask

  initial begin
    logic [63:0] pd;
    logic [31:0] ra;
    logic [1:0]  rc;
    rst   = 1'b1;
    bd_we = 1'b0;
    bd_addr = 12'd0;
    bd_data = 64'd0;
    if_a.proc2mem_command = C_NONE;
    if_a.proc2mem_addr    = 32'd0;
    if_a.proc2mem_data    = 64'd0;
    if_b.proc2mem_command = C_NONE;
    if_b.proc2mem_addr    = 32'd0;
    if_b.proc2mem_data    = 64'd0;

    // Backdoor preload while held in reset.
    for (int i = 0; i < 64; i++) begin
      pd = (i < 4) ? 64'hA0 + 64'(i) : {$urandom, $urandom};
      step(1'b1, C_NONE, 32'd0, 64'd0, 1'b1, 12'(i), pd);
    end

    ld(32'h8);
    idle(6);

    do_reset();
    for (int i = 0; i < 10; i++) ld(32'(i * 8));
    for (int i = 0; i < 6; i++) ld(32'h48);
    idle(12);

    st(32'h40, 64'hDEAD);
    ld(32'h40);
    idle(12);

    for (int i = 0; i < 30; i++) ld(32'($urandom_range(0, 63)) << 3);
    idle(12);

    ld(32'h0);
    ld(32'h8);
    ld(32'h10);
    do_reset();
    idle(2);
    ld(32'h10);
    idle(12);

    ld(32'h0010_0028);
    st(32'h0001_0028, 64'hFFFF_FFFF_FFFF_FFFF);
    ld(32'h28);
    ld(32'h0);
    idle(12);

    for (int n = 0; n < 400; n++) begin
      rc = 2'($urandom_range(0, 2));
      ra = (32'($urandom_range(0, 63)) << 3) | 32'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ra = ra | (32'd1 << $urandom_range(15, 31));
      step(($urandom_range(0, 59) == 0), rc, ra, {$urandom, $urandom},
           ($urandom_range(0, 7) == 0), 12'($urandom_range(0, 63)), {$urandom, $urandom});
    end
    idle(12);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
